alu_unit: RTL and testbench
===========================

ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have clk_in input 1: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have rst_in input 1: reset, synchronous and active-high.
REQ-003 SHALL have rdy_in input 1: when low, the block pauses and all state and outputs hold.
REQ-004 SHALL have clear_flag input 1: mispredict flush, synchronous.
REQ-005 SHALL have alu_op input 7: operation code; 0 = NOP/no issue.
REQ-006 SHALL have Vi input 32: operand A.
REQ-007 SHALL have Vj input 32: operand B when Itype=0.
REQ-008 SHALL have imm input 32: immediate, used as operand B when Itype=1 and as branch/jump offset.
REQ-009 SHALL have rd input 5: ROB id of the issuing entry.
REQ-010 SHALL have pc input 32: instruction PC.
REQ-011 SHALL have Itype input 1: selects imm as operand B.
REQ-012 SHALL have rs_ready output 1: result broadcast valid, one cycle per instruction.
REQ-013 SHALL have rs_ROB_id output 5: ROB id of the result.
REQ-014 SHALL have rs_val output 32: result value.
REQ-015 SHALL have br_valid output 1: the broadcast carries a control-flow resolution.
REQ-016 SHALL have br_taken output 1: branch/jump taken.
REQ-017 SHALL have br_target output 32: resolved next PC.
REQ-018 SHALL have busy output 1: a multi-cycle operation is in flight; upstream holds issue.

Function
REQ-019 SHALL use opcodes 1-14 ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,LUI,AUIPC,JAL,JALR; 15-20 BEQ,BNE,BLT,BGE,BLTU,BGEU; 21-28 MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU; 29-127 illegal.
REQ-020 SHALL accept an op when alu_op!=0, busy=0, rdy_in=1; ops presented while busy=1 are ignored.
REQ-021 SHALL register results for single-cycle ops (1-20, illegal): rs_ready=1 exactly one cycle after acceptance and 0 in every cycle with no completion.
REQ-022 SHALL use shift amount = operand B[4:0].
REQ-023 SHALL compute LUI=imm, AUIPC=pc+imm, wrapping mod 2^32.
REQ-024 SHALL, for JAL/JALR, give rs_val=pc+4, br_valid=1, br_taken=1, br_target=pc+imm (JAL) or (Vi+imm)&~1 (JALR).
REQ-025 SHALL, for branches, compare Vi with Vj regardless of Itype: rs_val=0, br_valid=1, br_taken=condition, br_target=taken?pc+imm:pc+4.
REQ-026 SHALL drive br_valid=0, br_taken=0, br_target=0 for non-control ops.
REQ-027 SHALL, for illegal ops, produce rs_ready=1 with rs_val=0.
REQ-028 SHALL complete multiply ops 2 cycles after acceptance, busy=1 during the intervening cycle.
REQ-029 SHALL run divide ops as a radix-2 restoring FSM IDLE->DIV(32 iterations)->DONE: result on rs_ready 34 cycles after acceptance, busy=1 from the cycle after acceptance until and including the DONE cycle.
REQ-030 SHALL return, for divide by zero: DIV/DIVU quotient 0xFFFFFFFF, REM/REMU dividend.
REQ-031 SHALL return, for DIV/REM of 0x80000000 by -1: quotient 0x80000000, remainder 0.
REQ-032 SHALL accept a new op in the DONE cycle (busy drops next cycle), with its result one cycle after the divide result.
REQ-033 SHALL, on clear_flag, abort any in-flight op, zero all outputs next cycle, and return the FSM to IDLE; an op presented with clear_flag is dropped.
REQ-034 SHALL, with rdy_in low, not advance counters or accept ops; a pending rs_ready pulse holds and is not duplicated.

Reset
REQ-035 SHALL, on rst_in=1, set all outputs to 0, the FSM to IDLE, and the iteration counter to 0, with priority over clear_flag and rdy_in.

Configuration
REQ-036 SHALL, with ALU_MDU_EN defined, implement opcodes 21-28 per REQ-028..031.
REQ-037 SHALL, without ALU_MDU_EN, treat opcodes 21-28 as illegal (REQ-027) with busy tied 0 and no multiplier/divider logic.

Verification
REQ-038 SHALL check ADD Vi=5, imm=-7, Itype=1, rd=3 -> next cycle rs_ready=1, rs_ROB_id=3, rs_val=0xFFFFFFFE.
REQ-039 SHALL check BLT Vi=-1, Vj=1, pc=0x100, imm=0x20 -> br_valid=1, br_taken=1, br_target=0x120, rs_val=0.
REQ-040 SHALL check JALR Vi=0x1001, imm=2, pc=0x40 -> rs_val=0x44, br_target=0x1002.
REQ-041 SHALL check DIV 0x80000000 by 0xFFFFFFFF -> busy high 33 cycles, rs_val=0x80000000 at cycle 34; DIVU 7/0 -> 0xFFFFFFFF.
REQ-042 SHALL check clear_flag at DIV cycle 10 -> busy=0 and rs_ready=0 next cycle, no late result.
REQ-043 SHALL check MUL 0x10000 by 0x10000 -> rs_val=0 at cycle 2; rdy_in low for 3 cycles in between -> completion delayed by 3 cycles, single pulse.

Source files
------------

// File: rtl/alu_unit.sv
// Integer execution unit: single-cycle ALU/branch ops with a registered result broadcast.
// Optional ALU_MDU_EN adds a 2-cycle multiplier and a 32-iteration restoring divider.
module alu_unit (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_flag,
    input  logic [6:0]  alu_op,
    input  logic [31:0] Vi,
    input  logic [31:0] Vj,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic [31:0] pc,
    input  logic        Itype,
    output logic        rs_ready,
    output logic [4:0]  rs_ROB_id,
    output logic [31:0] rs_val,
    output logic        br_valid,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam logic [6:0] OP_ADD  = 7'd1,  OP_SUB  = 7'd2,  OP_SLL  = 7'd3,  OP_SLT  = 7'd4;
    localparam logic [6:0] OP_SLTU = 7'd5,  OP_XOR  = 7'd6,  OP_SRL  = 7'd7,  OP_SRA  = 7'd8;
    localparam logic [6:0] OP_OR   = 7'd9,  OP_AND  = 7'd10, OP_LUI  = 7'd11, OP_AUIPC = 7'd12;
    localparam logic [6:0] OP_JAL  = 7'd13, OP_JALR = 7'd14, OP_BEQ  = 7'd15, OP_BNE  = 7'd16;
    localparam logic [6:0] OP_BLT  = 7'd17, OP_BGE  = 7'd18, OP_BLTU = 7'd19, OP_BGEU = 7'd20;

    logic [31:0] w_b;
    logic [4:0]  w_sh;
    logic [31:0] w_val, w_tgt;
    logic        w_brv, w_brt, w_cond;
    logic        w_busy;
    logic        w_nx_ready, w_nx_brv, w_nx_brt;
    logic [4:0]  w_nx_id;
    logic [31:0] w_nx_val, w_nx_tgt;
    logic        r_rs_ready, r_br_valid, r_br_taken;
    logic [4:0]  r_rs_id;
    logic [31:0] r_rs_val, r_br_target;

    assign w_b  = Itype ? imm : Vj;
    assign w_sh = w_b[4:0];

    // Branches always compare Vi against Vj; imm is only the offset.
    always_comb begin
        w_val  = '0;
        w_cond = 1'b0;
        w_brv  = 1'b0;
        w_brt  = 1'b0;
        w_tgt  = '0;
        case (alu_op)
            OP_ADD:   w_val = Vi + w_b;
            OP_SUB:   w_val = Vi - w_b;
            OP_SLL:   w_val = Vi << w_sh;
            OP_SLT:   w_val = {31'd0, $signed(Vi) < $signed(w_b)};
            OP_SLTU:  w_val = {31'd0, Vi < w_b};
            OP_XOR:   w_val = Vi ^ w_b;
            OP_SRL:   w_val = Vi >> w_sh;
            OP_SRA:   w_val = $signed(Vi) >>> w_sh;
            OP_OR:    w_val = Vi | w_b;
            OP_AND:   w_val = Vi & w_b;
            OP_LUI:   w_val = imm;
            OP_AUIPC: w_val = pc + imm;
            OP_JAL:   begin w_val = pc + 32'd4; w_brv = 1'b1; w_brt = 1'b1; w_tgt = pc + imm; end
            OP_JALR:  begin w_val = pc + 32'd4; w_brv = 1'b1; w_brt = 1'b1; w_tgt = (Vi + imm) & ~32'd1; end
            OP_BEQ:   w_cond = (Vi == Vj);
            OP_BNE:   w_cond = (Vi != Vj);
            OP_BLT:   w_cond = ($signed(Vi) < $signed(Vj));
            OP_BGE:   w_cond = ($signed(Vi) >= $signed(Vj));
            OP_BLTU:  w_cond = (Vi < Vj);
            OP_BGEU:  w_cond = (Vi >= Vj);
            default:  ;
        endcase
        if (alu_op >= OP_BEQ && alu_op <= OP_BGEU) begin
            w_brv = 1'b1;
            w_brt = w_cond;
            w_tgt = w_cond ? pc + imm : pc + 32'd4;
        end
    end

`ifdef ALU_MDU_EN
    localparam logic [6:0] OP_MUL = 7'd21, OP_MULH = 7'd22, OP_MULHSU = 7'd23, OP_MULHU = 7'd24;
    localparam logic [6:0] OP_DIV = 7'd25, OP_DIVU = 7'd26, OP_REM    = 7'd27, OP_REMU  = 7'd28;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} div_state_t;

    div_state_t  r_state;
    logic [4:0]  r_cnt, r_mul_id, r_div_id, r_hold_id;
    logic [6:0]  r_mul_op, r_div_op;
    logic [31:0] r_mul_a, r_mul_b, r_div_a, r_div_den, r_rem, r_quo, r_hold_val, r_hold_tgt;
    logic        r_mul_pend, r_div_bz, r_neg_q, r_neg_r, r_hold_v, r_hold_brv, r_hold_brt;
    logic        w_accept, w_is_mul, w_is_div, w_acc_mul, w_acc_div, w_acc_single, w_hold_load;
    logic        w_dsgn, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_mul_res, w_q, w_r, w_div_res;
    logic [63:0] w_ma, w_mb, w_prod;
    logic [32:0] w_rem_sh, w_diff;

    assign w_is_mul     = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
    assign w_is_div     = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
    assign w_busy       = r_mul_pend || (r_state != S_IDLE);
    assign w_accept     = (alu_op != 7'd0) && (!w_busy || r_state == S_DONE);
    assign w_acc_mul    = w_accept && w_is_mul;
    assign w_acc_div    = w_accept && w_is_div;
    assign w_acc_single = w_accept && !w_is_mul && !w_is_div;
    // A single-cycle op accepted while the divide result owns the bus is delayed one cycle.
    assign w_hold_load  = w_acc_single && (r_state == S_DONE || r_hold_v);

    assign w_ma      = {{32{(r_mul_op == OP_MULH || r_mul_op == OP_MULHSU) && r_mul_a[31]}}, r_mul_a};
    assign w_mb      = {{32{(r_mul_op == OP_MULH) && r_mul_b[31]}}, r_mul_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (r_mul_op == OP_MUL) ? w_prod[31:0] : w_prod[63:32];

    assign w_dsgn   = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign w_a_neg  = w_dsgn && Vi[31];
    assign w_b_neg  = w_dsgn && w_b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - Vi) : Vi;
    assign w_b_mag  = w_b_neg ? (32'd0 - w_b) : w_b;
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_div_den};

    always_comb begin
        w_q = r_neg_q ? (32'd0 - r_quo) : r_quo;
        w_r = r_neg_r ? (32'd0 - r_rem) : r_rem;
        if (r_div_bz) begin
            w_q = '1;
            w_r = r_div_a;
        end
        w_div_res = (r_div_op == OP_DIV || r_div_op == OP_DIVU) ? w_q : w_r;
    end

    always_comb begin
        w_nx_ready = 1'b0;
        w_nx_id    = '0;
        w_nx_val   = '0;
        w_nx_brv   = 1'b0;
        w_nx_brt   = 1'b0;
        w_nx_tgt   = '0;
        if (r_state == S_DONE) begin
            w_nx_ready = 1'b1; w_nx_id = r_div_id; w_nx_val = w_div_res;
        end else if (r_mul_pend) begin
            w_nx_ready = 1'b1; w_nx_id = r_mul_id; w_nx_val = w_mul_res;
        end else if (r_hold_v) begin
            w_nx_ready = 1'b1; w_nx_id = r_hold_id; w_nx_val = r_hold_val;
            w_nx_brv = r_hold_brv; w_nx_brt = r_hold_brt; w_nx_tgt = r_hold_tgt;
        end else if (w_acc_single) begin
            w_nx_ready = 1'b1; w_nx_id = rd; w_nx_val = w_val;
            w_nx_brv = w_brv; w_nx_brt = w_brt; w_nx_tgt = w_tgt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_flag) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mul_pend <= 1'b0;
            r_hold_v   <= 1'b0;
        end else if (rdy_in) begin
            r_mul_pend <= w_acc_mul;
            r_hold_v   <= w_hold_load;
            if (w_acc_mul) begin
                r_mul_op <= alu_op; r_mul_a <= Vi; r_mul_b <= w_b; r_mul_id <= rd;
            end
            if (w_hold_load) begin
                r_hold_id <= rd; r_hold_val <= w_val;
                r_hold_brv <= w_brv; r_hold_brt <= w_brt; r_hold_tgt <= w_tgt;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_acc_div) begin
                        r_state   <= S_DIV;
                        r_cnt     <= '0;
                        r_div_op  <= alu_op;
                        r_div_id  <= rd;
                        r_div_a   <= Vi;
                        r_div_den <= w_b_mag;
                        r_div_bz  <= (w_b == 32'd0);
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_quo     <= w_a_mag;
                        r_rem     <= '0;
                    end
                end
                S_DIV: begin
                    if (!w_diff[32]) begin
                        r_rem <= w_diff[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state = r_state;
`else
    assign w_busy = 1'b0;

    always_comb begin
        w_nx_ready = 1'b0;
        w_nx_id    = '0;
        w_nx_val   = '0;
        w_nx_brv   = 1'b0;
        w_nx_brt   = 1'b0;
        w_nx_tgt   = '0;
        if (alu_op != 7'd0) begin
            w_nx_ready = 1'b1; w_nx_id = rd; w_nx_val = w_val;
            w_nx_brv = w_brv; w_nx_brt = w_brt; w_nx_tgt = w_tgt;
        end
    end

    assign dbg_state = 2'd0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_flag) begin
            r_rs_ready  <= 1'b0;
            r_rs_id     <= '0;
            r_rs_val    <= '0;
            r_br_valid  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else if (rdy_in) begin
            r_rs_ready  <= w_nx_ready;
            r_rs_id     <= w_nx_id;
            r_rs_val    <= w_nx_val;
            r_br_valid  <= w_nx_brv;
            r_br_taken  <= w_nx_brt;
            r_br_target <= w_nx_tgt;
        end
    end

    assign rs_ready  = r_rs_ready;
    assign rs_ROB_id = r_rs_id;
    assign rs_val    = r_rs_val;
    assign br_valid  = r_br_valid;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;
    assign busy      = w_busy;
endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed corner cases plus randomized ops against a reference model.
module tb_alu_unit;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_flag, Itype;
    logic [6:0]  alu_op;
    logic [31:0] Vi, Vj, imm, pc;
    logic [4:0]  rd;
    logic        rs_ready, br_valid, br_taken, busy;
    logic [4:0]  rs_ROB_id;
    logic [31:0] rs_val, br_target;
    logic [1:0]  dbg_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_val, last_tgt;

    alu_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .alu_op(alu_op), .Vi(Vi), .Vj(Vj), .imm(imm), .rd(rd), .pc(pc), .Itype(Itype),
        .rs_ready(rs_ready), .rs_ROB_id(rs_ROB_id), .rs_val(rs_val),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (n_tests=%0d)", n_tests);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour from the instruction definitions, in plain 64-bit arithmetic.
    function automatic void model(input logic [6:0] op, input logic [31:0] a, bv, im, p,
                                  input logic it, output logic [31:0] val, output logic brv,
                                  output logic brt, output logic [31:0] tgt,
                                  output int lat, output int bsy);
        logic [31:0]     b;
        longint          sa, sb, sbv, d, q;
        longint unsigned ua, ub, ubv;
        int              sh;
        logic            cond;
        b   = it ? im : bv;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sbv = longint'($signed(bv));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ubv = {32'd0, bv};
        sh  = int'(ub % 64'd32);
        val = 32'd0; brv = 1'b0; brt = 1'b0; tgt = 32'd0; lat = 1; bsy = 0; cond = 1'b0;
        case (op)
            7'd1:  val = 32'(ua + ub);
            7'd2:  val = 32'(ua - ub);
            7'd3:  val = 32'(ua * (64'd1 << sh));
            7'd4:  val = (sa < sb) ? 32'd1 : 32'd0;
            7'd5:  val = (ua < ub) ? 32'd1 : 32'd0;
            7'd6:  val = a ^ b;
            7'd7:  val = 32'(ua / (64'd1 << sh));
            7'd8:  begin
                d = 64'sd1 << sh;
                q = sa / d;
                if (sa < 0 && (sa % d) != 0) q = q - 1;
                val = 32'(q);
            end
            7'd9:  val = a | b;
            7'd10: val = a & b;
            7'd11: val = im;
            7'd12: val = p + im;
            7'd13: begin val = p + 32'd4; brv = 1'b1; brt = 1'b1; tgt = p + im; end
            7'd14: begin val = p + 32'd4; brv = 1'b1; brt = 1'b1; tgt = (a + im) & 32'hFFFF_FFFE; end
            7'd15, 7'd16, 7'd17, 7'd18, 7'd19, 7'd20: begin
                case (op)
                    7'd15:   cond = (a == bv);
                    7'd16:   cond = (a != bv);
                    7'd17:   cond = (sa < sbv);
                    7'd18:   cond = (sa >= sbv);
                    7'd19:   cond = (ua < ubv);
                    default: cond = (ua >= ubv);
                endcase
                brv = 1'b1; brt = cond; tgt = cond ? p + im : p + 32'd4;
            end
`ifdef ALU_MDU_EN
            7'd21: begin val = 32'(sa * sb); lat = 2; bsy = 1; end
            7'd22: begin val = 32'((sa * sb) >>> 32); lat = 2; bsy = 1; end
            7'd23: begin val = 32'((sa * longint'(ub)) >>> 32); lat = 2; bsy = 1; end
            7'd24: begin val = 32'((ua * ub) >> 32); lat = 2; bsy = 1; end
            7'd25, 7'd27: begin
                lat = 34; bsy = 33;
                if (b == 32'd0)                              val = (op == 7'd25) ? 32'hFFFF_FFFF : a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) val = (op == 7'd25) ? a : 32'd0;
                else                                         val = (op == 7'd25) ? 32'(sa / sb) : 32'(sa % sb);
            end
            7'd26, 7'd28: begin
                lat = 34; bsy = 33;
                if (b == 32'd0) val = (op == 7'd26) ? 32'hFFFF_FFFF : a;
                else            val = (op == 7'd26) ? 32'(ua / ub) : 32'(ua % ub);
            end
`endif
            default: val = 32'd0;
        endcase
    endfunction

    task automatic drive_op(input logic [6:0] op, input logic [31:0] a, bv, im, p,
                            input logic [4:0] id, input logic it);
        alu_op = op; Vi = a; Vj = bv; imm = im; pc = p; rd = id; Itype = it;
    endtask

    // Issue one op from idle, wait (bounded) for its broadcast and score every output.
    task automatic run_op(input logic [6:0] op, input logic [31:0] a, bv, im, p,
                          input logic [4:0] id, input logic it);
        logic [31:0] e_val, e_tgt;
        logic        e_brv, e_brt;
        int          e_lat, e_bsy, lat, bsy;
        model(op, a, bv, im, p, it, e_val, e_brv, e_brt, e_tgt, e_lat, e_bsy);
        exp_q.push_back(e_val);
        @(negedge clk_in);
        drive_op(op, a, bv, im, p, id, it);
        @(negedge clk_in);
        alu_op = 7'd0;
        lat = 1;
        bsy = busy ? 1 : 0;
        while (!rs_ready && lat < 200) begin
            @(negedge clk_in);
            lat++;
            if (busy) bsy++;
        end
        last_val = rs_val;
        last_tgt = br_target;
        check($sformatf("ready op%0d", op), {31'd0, rs_ready}, 32'd1);
        check($sformatf("latency op%0d", op), lat, e_lat);
        check($sformatf("busy_cycles op%0d", op), bsy, e_bsy);
        check($sformatf("rob_id op%0d", op), {27'd0, rs_ROB_id}, {27'd0, id});
        check($sformatf("rs_val op%0d", op), rs_val, exp_q.pop_front());
        check($sformatf("br_valid op%0d", op), {31'd0, br_valid}, {31'd0, e_brv});
        check($sformatf("br_taken op%0d", op), {31'd0, br_taken}, {31'd0, e_brt});
        check($sformatf("br_target op%0d", op), br_target, e_tgt);
        @(negedge clk_in);
        check($sformatf("pulse_end op%0d", op), {31'd0, rs_ready}, 32'd0);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int         pulses;
        logic [6:0] op;
        // Reset wins over clear_flag, rdy_in and a presented op.
        rst_in = 1'b1; clear_flag = 1'b1; rdy_in = 1'b0;
        drive_op(7'd1, 32'd3, 32'd4, 32'd0, 32'd0, 5'd1, 1'b0);
        repeat (3) @(negedge clk_in);
        rdy_in = 1'b1; clear_flag = 1'b0;
        @(negedge clk_in);
        check("reset rs_ready", {31'd0, rs_ready}, 32'd0);
        check("reset rs_val", rs_val, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        rst_in = 1'b0; alu_op = 7'd0;
        @(negedge clk_in);

        run_op(7'd1, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'd0, 5'd3, 1'b1);
        check("add_imm value", last_val, 32'hFFFF_FFFE);
        run_op(7'd17, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd5, 1'b1);
        check("blt target", last_tgt, 32'h120);
        run_op(7'd14, 32'h1001, 32'd0, 32'd2, 32'h40, 5'd6, 1'b0);
        check("jalr link", last_val, 32'h44);
        check("jalr target", last_tgt, 32'h1002);
        run_op(7'd99, 32'd12, 32'd34, 32'd56, 32'h200, 5'd8, 1'b0);

        // Broadcast pulse holds while rdy_in is low and is not repeated.
        @(negedge clk_in);
        drive_op(7'd1, 32'd10, 32'd20, 32'd0, 32'd0, 5'd7, 1'b0);
        @(negedge clk_in);
        alu_op = 7'd0; rdy_in = 1'b0;
        check("rdy pulse", {31'd0, rs_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk_in);
            check("rdy hold ready", {31'd0, rs_ready}, 32'd1);
            check("rdy hold val", rs_val, 32'd30);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("rdy release", {31'd0, rs_ready}, 32'd0);

        // An op presented together with clear_flag is dropped.
        drive_op(7'd1, 32'd1, 32'd1, 32'd0, 32'd0, 5'd2, 1'b0);
        clear_flag = 1'b1;
        @(negedge clk_in);
        alu_op = 7'd0; clear_flag = 1'b0;
        check("clear drop", {31'd0, rs_ready}, 32'd0);
        // A pending broadcast is wiped by clear_flag.
        drive_op(7'd13, 32'd0, 32'd0, 32'h80, 32'h1000, 5'd9, 1'b0);
        @(negedge clk_in);
        alu_op = 7'd0; clear_flag = 1'b1;
        check("clear pre ready", {31'd0, br_valid}, 32'd1);
        @(negedge clk_in);
        clear_flag = 1'b0;
        check("clear flush ready", {31'd0, rs_ready}, 32'd0);
        check("clear flush br_valid", {31'd0, br_valid}, 32'd0);
        check("clear flush rs_val", rs_val, 32'd0);

`ifdef ALU_MDU_EN
        run_op(7'd25, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd10, 1'b0);
        check("div overflow", last_val, 32'h8000_0000);
        run_op(7'd26, 32'd7, 32'd0, 32'd0, 32'd0, 5'd11, 1'b0);
        check("divu by zero", last_val, 32'hFFFF_FFFF);
        run_op(7'd27, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 5'd12, 1'b0);

        // Abort a divide in its tenth cycle; nothing may come out later.
        @(negedge clk_in);
        drive_op(7'd25, 32'd100, 32'd7, 32'd0, 32'd0, 5'd13, 1'b0);
        @(negedge clk_in);
        alu_op = 7'd0;
        repeat (9) @(negedge clk_in);
        check("div busy mid", {31'd0, busy}, 32'd1);
        clear_flag = 1'b1;
        @(negedge clk_in);
        clear_flag = 1'b0;
        check("div clear busy", {31'd0, busy}, 32'd0);
        check("div clear ready", {31'd0, rs_ready}, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (rs_ready) pulses++;
        end
        check("div no late result", pulses, 0);

        // Multiply with rdy_in low for three cycles mid-flight.
        drive_op(7'd21, 32'h10000, 32'h10000, 32'd0, 32'd0, 5'd14, 1'b0);
        @(negedge clk_in);
        alu_op = 7'd0; rdy_in = 1'b0;
        check("mul busy", {31'd0, busy}, 32'd1);
        repeat (3) begin
            @(negedge clk_in);
            check("mul stalled ready", {31'd0, rs_ready}, 32'd0);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("mul stalled done", {31'd0, rs_ready}, 32'd1);
        check("mul stalled val", rs_val, 32'd0);
        @(negedge clk_in);
        check("mul single pulse", {31'd0, rs_ready}, 32'd0);

        // New op accepted in the divider's final busy cycle.
        drive_op(7'd26, 32'd1000, 32'd10, 32'd0, 32'd0, 5'd4, 1'b0);
        @(negedge clk_in);
        alu_op = 7'd0;
        repeat (32) @(negedge clk_in);
        check("done busy", {31'd0, busy}, 32'd1);
        drive_op(7'd1, 32'd1, 32'd2, 32'd0, 32'd0, 5'd9, 1'b0);
        @(negedge clk_in);
        alu_op = 7'd0;
        check("done div ready", {31'd0, rs_ready}, 32'd1);
        check("done div id", {27'd0, rs_ROB_id}, 32'd4);
        check("done div val", rs_val, 32'd100);
        check("done busy drop", {31'd0, busy}, 32'd0);
        @(negedge clk_in);
        check("follow ready", {31'd0, rs_ready}, 32'd1);
        check("follow id", {27'd0, rs_ROB_id}, 32'd9);
        check("follow val", rs_val, 32'd3);
        @(negedge clk_in);
        check("follow end", {31'd0, rs_ready}, 32'd0);

        // An op presented mid-divide is ignored: exactly one broadcast.
        drive_op(7'd28, 32'd50, 32'd7, 32'd0, 32'd0, 5'd15, 1'b0);
        @(negedge clk_in);
        drive_op(7'd1, 32'd1, 32'd1, 32'd0, 32'd0, 5'd16, 1'b0);
        @(negedge clk_in);
        alu_op = 7'd0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (rs_ready) begin
                pulses++;
                check("busy ignore id", {27'd0, rs_ROB_id}, 32'd15);
                check("busy ignore val", rs_val, 32'd1);
            end
        end
        check("busy ignore pulses", pulses, 1);
`endif

        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(29, 127)) : 7'($urandom_range(1, 28));
            run_op(op, rand_word(), rand_word(), rand_word(), $urandom & 32'hFFFF_FFFC,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
